// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the 256-bit physical-memory line interface.
package pmem_pkg;

    typedef logic [255:0] pmem_line_t;
    typedef logic [15:0]  pmem_addr_t;

    localparam int PMEM_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } pmem_state_e;

endpackage

// File: rtl/pmem_responder_if.sv
// Line-interface bundle between a requester (master) and the memory responder (slave).
interface pmem_if;
    import pmem_pkg::*;

    logic       pmem_read;
    logic       pmem_write;
    pmem_addr_t pmem_address;
    pmem_line_t pmem_wdata;
    logic       pmem_resp;
    pmem_line_t pmem_rdata;
    logic       pmem_error;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata, pmem_error
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata, pmem_error
    );

endinterface

// File: rtl/pmem_line_ram.sv
// Single-port DEPTH x 256 line array; registered read port that only updates on a read enable.
module pmem_line_ram
    import pmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  pmem_line_t               wdata_i,
    output pmem_line_t               rdata_o
);

    pmem_line_t mem_q [DEPTH];
    pmem_line_t rdata_q;

    // Array contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Write-first when both enables hit the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency synthesizable responder for 256-bit line reads/writes, one transaction at a time.
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic  clk,
    input  logic  rst_n,
    pmem_if.slave pmem
);

    localparam int IDX_W = $clog2(DEPTH);

    pmem_state_e      state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             resp_q, resp_d;
    logic             error_q, error_d;
    logic             op_wr_q, op_wr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    pmem_line_t       wdata_q, wdata_d;

    logic             req;
    logic [IDX_W-1:0] in_idx;
    logic             ram_we;
    logic             ram_re;
    logic [IDX_W-1:0] ram_idx;
    pmem_line_t       ram_wdata;
    pmem_line_t       ram_rdata;

    assign req    = pmem.pmem_read | pmem.pmem_write;
    assign in_idx = pmem.pmem_address[PMEM_OFFSET_BITS +: IDX_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        error_d   = error_q;
        op_wr_d   = op_wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        resp_d    = (state_q == RESP);
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_idx   = idx_q;
        ram_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    op_wr_d = pmem.pmem_write;
                    idx_d   = in_idx;
                    wdata_d = pmem.pmem_wdata;
                    if (pmem.pmem_read && pmem.pmem_write) begin
                        error_d = 1'b1;
                    end
                    // With unit latency the commit edge is the sample edge, so use live inputs.
                    if (LATENCY == 1) begin
                        state_d   = RESP;
                        ram_idx   = in_idx;
                        ram_wdata = pmem.pmem_wdata;
                        ram_we    = pmem.pmem_write;
                        ram_re    = ~pmem.pmem_write;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 8'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (op_wr_q ? !pmem.pmem_write : !pmem.pmem_read) begin
                    error_d = 1'b1;
                end
                if (cnt_q == 8'd1) begin
                    state_d = RESP;
                    ram_we  = op_wr_q;
                    ram_re  = ~op_wr_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            error_q <= error_d;
        end
    end

    // Latched request payload; only meaningful while a transaction is in flight.
    always_ff @(posedge clk) begin
        op_wr_q <= op_wr_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    pmem_line_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .idx_i   (ram_idx),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign pmem.pmem_resp  = resp_q;
    assign pmem.pmem_rdata = ram_rdata;
    assign pmem.pmem_error = error_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized and directed bench for pmem_responder against a line-array reference model.
module tb_pmem_responder;
    import pmem_pkg::*;

    localparam int L4 = 4;
    localparam int L1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmem_if bus4 ();
    pmem_if bus1 ();

    pmem_responder #(.LATENCY(L4), .DEPTH(256)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .pmem  (bus4)
    );

    pmem_responder #(.LATENCY(L1), .DEPTH(256)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .pmem  (bus1)
    );

    int checks = 0;
    int errors = 0;

    pmem_line_t ref_mem [256];
    bit         ref_vld [256];
    pmem_line_t ref_rdata;
    bit         ref_err;
    int         written_q [$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic pmem_line_t rand_line();
        pmem_line_t v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // One transaction on the LATENCY=4 instance; drop_after>0 releases the request after that many cycles.
    task automatic xact(input string tag, input bit rd, input bit wr, input pmem_addr_t addr,
                        input pmem_line_t wd, input int drop_after);
        int  n;
        bit  seen;
        int  idx;
        idx = int'(addr[12:5]);
        if (wr) begin
            ref_mem[idx] = wd;
            if (!ref_vld[idx]) written_q.push_back(idx);
            ref_vld[idx] = 1'b1;
        end else if (rd) begin
            ref_rdata = ref_mem[idx];
        end
        if (rd && wr) ref_err = 1'b1;
        if (drop_after > 0 && drop_after < L4) ref_err = 1'b1;

        bus4.pmem_read    = rd;
        bus4.pmem_write   = wr;
        bus4.pmem_address = addr;
        bus4.pmem_wdata   = wd;
        @(posedge clk);
        #1;
        bus4.pmem_address = pmem_addr_t'($urandom);
        bus4.pmem_wdata   = ~wd;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (bus4.pmem_resp) begin
                seen = 1'b1;
            end else begin
                if (drop_after > 0 && n + 1 == drop_after) begin
                    bus4.pmem_read  = 1'b0;
                    bus4.pmem_write = 1'b0;
                end
                @(posedge clk);
                n++;
            end
        end
        chk({tag, "_lat"}, n, L4);
        bus4.pmem_read  = 1'b0;
        bus4.pmem_write = 1'b0;
        if (rd && !wr) chk({tag, "_rdata"}, bus4.pmem_rdata, ref_rdata);
        chk({tag, "_err"}, bus4.pmem_error, ref_err);
        @(negedge clk);
        chk({tag, "_pulse1"}, bus4.pmem_resp, 1'b0);
        chk({tag, "_hold"}, bus4.pmem_rdata, ref_rdata);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        ref_rdata = '0;
        ref_err   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    pmem_line_t a_line, b_line, c_line, d_line, wd;
    pmem_addr_t addr;
    bit         rd;
    int         idx;
    logic [11:0] got_pat, exp_pat;
    int         consec;

    initial begin
        bus4.pmem_read = 1'b0; bus4.pmem_write = 1'b0; bus4.pmem_address = '0; bus4.pmem_wdata = '0;
        bus1.pmem_read = 1'b0; bus1.pmem_write = 1'b0; bus1.pmem_address = '0; bus1.pmem_wdata = '0;
        ref_rdata = '0;
        ref_err   = 1'b0;
        for (int i = 0; i < 256; i++) ref_vld[i] = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_resp", bus4.pmem_resp, 1'b0);
        chk("rst_rdata", bus4.pmem_rdata, '0);
        chk("rst_err", bus4.pmem_error, 1'b0);
        chk("rst_resp1", bus1.pmem_resp, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        xact("wr40", 1'b0, 1'b1, 16'h0040, {8{32'hDEADBEEF}}, 0);
        xact("rd40", 1'b1, 1'b0, 16'h0040, '0, 0);
        chk("rd40_val", bus4.pmem_rdata, {8{32'hDEADBEEF}});

        a_line = rand_line();
        xact("wrA", 1'b0, 1'b1, 16'h0020, a_line, 0);
        xact("rdA_alias", 1'b1, 1'b0, 16'h2025, '0, 0);
        chk("alias_val", bus4.pmem_rdata, a_line);

        for (int t = 0; t < 30; t++) begin
            rd = ($urandom_range(0, 1) == 1);
            if (rd) begin
                idx = written_q[$urandom_range(0, written_q.size() - 1)];
                wd  = '0;
            end else begin
                idx = $urandom_range(0, 255);
                wd  = rand_line();
            end
            addr = {3'($urandom), 8'(idx), 5'($urandom)};
            xact(rd ? "rnd_rd" : "rnd_wr", rd, !rd, addr, wd, 0);
        end

        xact("drop", 1'b1, 1'b0, 16'h0040, '0, 2);
        pulse_reset();
        chk("clr_err", bus4.pmem_error, 1'b0);

        b_line = rand_line();
        xact("both", 1'b1, 1'b1, 16'h0100, b_line, 0);
        xact("rdB", 1'b1, 1'b0, 16'h0100, '0, 0);
        chk("rdB_val", bus4.pmem_rdata, b_line);

        c_line = rand_line();
        d_line = ~c_line;
        xact("wrC", 1'b0, 1'b1, 16'h0080, c_line, 0);
        bus4.pmem_write   = 1'b1;
        bus4.pmem_address = 16'h0080;
        bus4.pmem_wdata   = d_line;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        ref_rdata = '0;
        ref_err   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstmid_resp", bus4.pmem_resp, 1'b0);
        end
        chk("rstmid_rdata", bus4.pmem_rdata, '0);
        chk("rstmid_err", bus4.pmem_error, 1'b0);
        bus4.pmem_write = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        xact("rdC", 1'b1, 1'b0, 16'h0080, '0, 0);
        chk("rdC_val", bus4.pmem_rdata, c_line);

        // Unit-latency instance: read held high continuously.
        bus1.pmem_read = 1'b1;
        got_pat = '0;
        exp_pat = '0;
        consec  = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            got_pat[i] = bus1.pmem_resp;
            exp_pat[i] = ((i % (L1 + 1)) == L1);
            if (i > 0 && got_pat[i] && got_pat[i-1]) consec++;
        end
        bus1.pmem_read = 1'b0;
        chk("l1_pattern", got_pat, exp_pat);
        chk("l1_consec", consec, 0);
        chk("l1_err", bus1.pmem_error, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
